// File: rtl/vga_console_ctl.sv
`timescale 1ns/1ps
// Purpose: byte-stream text console engine; writes glyphs, handles CR/LF/BS/FF, scrolls the 80x40 text RAM.
// Latency: printable/BS write strobes the cycle after acceptance, idle again one cycle later; scroll 6320 cycles, clear 3200.
// Backpressure: in_ready (== idle) low for the whole of any RAM sequence; a held byte is taken on the first idle edge.
//
// Ports:
//   clk, reset_n              core clock, synchronous active-low reset
//   in_valid/in_char/in_ready byte input handshake
//   mem_strobe/mem_rw/mem_addr/mem_wdata/mem_rdata  text RAM core-side port (rdata one cycle after a read)
//   crx/cry                   cursor to the VGA core: 1-based column, 0-based row
//   busy                      inverse of in_ready

`ifndef VIDEO_ADDR
`define VIDEO_ADDR 32'h000B_8000
`endif

module vga_console_ctl #(
    parameter logic [31:0] VIDEO_ADDR = `VIDEO_ADDR,
    parameter int          ROWS       = 40,
    parameter int          COLS       = 80,
    parameter logic [7:0]  BLANK      = 8'h20
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic [7:0]  in_char,
    output logic        in_ready,
    output logic        mem_strobe,
    output logic        mem_rw,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic [6:0]  crx,
    output logic [5:0]  cry,
    output logic        busy
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PUT     = 3'd1;
    localparam logic [2:0] S_SCR_RD  = 3'd2;
    localparam logic [2:0] S_SCR_WR  = 3'd3;
    localparam logic [2:0] S_SCR_CLR = 3'd4;
    localparam logic [2:0] S_CLR     = 3'd5;

    localparam logic [11:0] COLS12    = 12'(COLS);
    localparam logic [11:0] LAST_COPY = 12'((ROWS - 1) * COLS - 1);
    localparam logic [11:0] LAST_CELL = 12'(ROWS * COLS - 1);
    localparam logic [6:0]  COLS_M1   = 7'(COLS - 1);
    localparam logic [5:0]  ROWS_M1   = 6'(ROWS - 1);

    logic [2:0]  state;
    logic [6:0]  cx;
    logic [5:0]  cy;
    logic [11:0] idx;
    logic        put_adv;   // PUT advances the cursor (printable) or not (backspace blank)
    logic [7:0]  wdata_q;
    logic [11:0] cur_idx;

    function automatic logic [31:0] cell_addr(input logic [11:0] i);
        return VIDEO_ADDR + {20'b0, i};
    endfunction

    assign cur_idx  = 12'(cy) * COLS12 + {5'b0, cx};
    assign in_ready = (state == S_IDLE);
    assign busy     = ~in_ready;
    assign crx      = cx + 7'd1;
    assign cry      = cy;

    // Scroll copy forwards the read data straight through in the write cycle,
    // since it only arrives the cycle after the read strobe.
    assign mem_wdata = (state == S_SCR_WR) ? {24'b0, mem_rdata} : {24'b0, wdata_q};

    // Outputs are registered together with the state they belong to, so
    // mem_strobe is high exactly while the FSM sits in an access state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            cx         <= '0;
            cy         <= '0;
            idx        <= '0;
            put_adv    <= 1'b0;
            mem_strobe <= 1'b0;
            mem_rw     <= 1'b0;
            mem_addr   <= VIDEO_ADDR;
            wdata_q    <= '0;
        end else begin
            mem_strobe <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        case (in_char)
                            8'h0D: cx <= '0;
                            8'h0A: begin
                                cx <= '0;
                                if (cy == ROWS_M1) begin
                                    state      <= S_SCR_RD;
                                    idx        <= '0;
                                    mem_strobe <= 1'b1;
                                    mem_rw     <= 1'b0;
                                    mem_addr   <= cell_addr(COLS12);
                                end else begin
                                    cy <= cy + 6'd1;
                                end
                            end
                            8'h08: begin
                                // No reverse wrap: backspace at column 0 does nothing.
                                if (cx != '0) begin
                                    cx         <= cx - 7'd1;
                                    state      <= S_PUT;
                                    put_adv    <= 1'b0;
                                    mem_strobe <= 1'b1;
                                    mem_rw     <= 1'b1;
                                    mem_addr   <= cell_addr(cur_idx - 12'd1);
                                    wdata_q    <= BLANK;
                                end
                            end
                            8'h0C: begin
                                state      <= S_CLR;
                                idx        <= '0;
                                mem_strobe <= 1'b1;
                                mem_rw     <= 1'b1;
                                mem_addr   <= VIDEO_ADDR;
                                wdata_q    <= BLANK;
                            end
                            default: begin
                                state      <= S_PUT;
                                put_adv    <= 1'b1;
                                mem_strobe <= 1'b1;
                                mem_rw     <= 1'b1;
                                mem_addr   <= cell_addr(cur_idx);
                                wdata_q    <= in_char;
                            end
                        endcase
                    end
                end
                S_PUT: begin
                    state <= S_IDLE;
                    if (put_adv) begin
                        if (cx == COLS_M1) begin
                            cx <= '0;
                            if (cy == ROWS_M1) begin
                                state      <= S_SCR_RD;
                                idx        <= '0;
                                mem_strobe <= 1'b1;
                                mem_rw     <= 1'b0;
                                mem_addr   <= cell_addr(COLS12);
                            end else begin
                                cy <= cy + 6'd1;
                            end
                        end else begin
                            cx <= cx + 7'd1;
                        end
                    end
                end
                S_SCR_RD: begin
                    state      <= S_SCR_WR;
                    mem_strobe <= 1'b1;
                    mem_rw     <= 1'b1;
                    mem_addr   <= cell_addr(idx);
                end
                S_SCR_WR: begin
                    idx        <= idx + 12'd1;
                    mem_strobe <= 1'b1;
                    if (idx == LAST_COPY) begin
                        // idx+1 is the first cell of the bottom row.
                        state    <= S_SCR_CLR;
                        mem_rw   <= 1'b1;
                        mem_addr <= cell_addr(idx + 12'd1);
                        wdata_q  <= BLANK;
                    end else begin
                        state    <= S_SCR_RD;
                        mem_rw   <= 1'b0;
                        mem_addr <= cell_addr(idx + 12'd1 + COLS12);
                    end
                end
                S_SCR_CLR, S_CLR: begin
                    if (idx == LAST_CELL) begin
                        state <= S_IDLE;
                        if (state == S_CLR) begin
                            cx <= '0;
                            cy <= '0;
                        end
                    end else begin
                        idx        <= idx + 12'd1;
                        mem_strobe <= 1'b1;
                        mem_rw     <= 1'b1;
                        mem_addr   <= cell_addr(idx + 12'd1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_console_ctl.sv
`timescale 1ns/1ps
// Purpose: self-checking bench for vga_console_ctl with a text RAM model and an access scoreboard.
// Latency: n/a (bench).
// Backpressure: bytes are offered only when in_ready is high, except in the held-byte sequence.

module tb_vga_console_ctl;

    localparam logic [31:0] BASE = 32'h000B_8000;
    localparam int ROWS = 40;
    localparam int COLS = 80;
    localparam int CELLS = ROWS * COLS;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_char = 8'h00;
    logic        in_ready;
    logic        mem_strobe;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_rdata;
    logic [6:0]  crx;
    logic [5:0]  cry;
    logic        busy;

    always #5 clk = ~clk;

    vga_console_ctl #(.VIDEO_ADDR(BASE), .ROWS(ROWS), .COLS(COLS), .BLANK(8'h20)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_char(in_char), .in_ready(in_ready),
        .mem_strobe(mem_strobe), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .crx(crx), .cry(cry), .busy(busy)
    );

    int errors = 0;
    int checks = 0;
    int nstrobe = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- text RAM model ----------------
    logic [7:0] ram [0:4095];
    logic       do_preload = 1'b0;

    function automatic logic [7:0] pat(input int i);
        return 8'((i * 37 + 11) & 255);
    endfunction

    always @(posedge clk) begin
        if (do_preload) begin
            for (int i = 0; i < 4096; i++) ram[i] <= pat(i);
        end else if (mem_strobe) begin
            if (mem_rw) ram[12'(mem_addr - BASE)] <= mem_wdata[7:0];
            else        mem_rdata <= ram[12'(mem_addr - BASE)];
        end
    end

    // ---------------- access scoreboard ----------------
    typedef struct {
        bit         rw;
        logic [31:0] addr;
        logic [7:0]  dat;
    } acc_t;

    acc_t exp_q[$];

    task automatic exp_acc(input bit rw, input int off, input logic [7:0] d);
        acc_t a;
        a.rw   = rw;
        a.addr = BASE + 32'(off);
        a.dat  = d;
        exp_q.push_back(a);
    endtask

    always @(negedge clk) begin
        if (mem_strobe) begin
            nstrobe++;
            chk("no_strobe_in_idle", {31'b0, in_ready}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_access_addr", mem_addr, 32'hFFFF_FFFF);
            end else begin
                acc_t a;
                a = exp_q.pop_front();
                chk("acc_rw", {31'b0, mem_rw}, {31'b0, a.rw});
                chk("acc_addr", mem_addr, a.addr);
                if (a.rw) chk("acc_wdata", mem_wdata, {24'b0, a.dat});
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic do_reset();
        reset_n  = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (!in_ready && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, {31'b0, in_ready}, 32'd1);
    endtask

    // Offers one byte; returns #1 after the accepting edge.
    task automatic send(input logic [7:0] c);
        @(negedge clk);
        wait_idle(8000, "send_ready_timeout");
        in_valid = 1'b1;
        in_char  = c;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    typedef struct {
        logic [7:0] ch;
        bit         wr;
        int         off;
        logic [7:0] dat;
        int         ecrx;
        int         ecry;
    } vec_t;

    vec_t vec [16];

    initial begin
        int bad;
        int n;

        vec[0]  = '{8'h41, 1'b1, 0,  8'h41, 2, 0};
        vec[1]  = '{8'h42, 1'b1, 1,  8'h42, 3, 0};
        vec[2]  = '{8'h0D, 1'b0, 0,  8'h00, 1, 0};
        vec[3]  = '{8'h0A, 1'b0, 0,  8'h00, 1, 1};
        vec[4]  = '{8'h78, 1'b1, 80, 8'h78, 2, 1};
        vec[5]  = '{8'h08, 1'b1, 80, 8'h20, 1, 1};
        vec[6]  = '{8'h08, 1'b0, 0,  8'h00, 1, 1};
        vec[7]  = '{8'h71, 1'b1, 80, 8'h71, 2, 1};
        vec[8]  = '{8'h72, 1'b1, 81, 8'h72, 3, 1};
        vec[9]  = '{8'h73, 1'b1, 82, 8'h73, 4, 1};
        vec[10] = '{8'h74, 1'b1, 83, 8'h74, 5, 1};
        vec[11] = '{8'h75, 1'b1, 84, 8'h75, 6, 1};
        vec[12] = '{8'h08, 1'b1, 84, 8'h20, 5, 1};
        vec[13] = '{8'h43, 1'b1, 84, 8'h43, 6, 1};
        vec[14] = '{8'h0D, 1'b0, 0,  8'h00, 1, 1};
        vec[15] = '{8'h0A, 1'b0, 0,  8'h00, 1, 2};

        // ---- reset state ----
        do_reset();
        @(negedge clk);
        chk("rst_strobe", {31'b0, mem_strobe}, 32'd0);
        chk("rst_rw", {31'b0, mem_rw}, 32'd0);
        chk("rst_addr", mem_addr, BASE);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_crx", 32'(crx), 32'd1);
        chk("rst_cry", 32'(cry), 32'd0);
        chk("rst_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);

        // ---- table-driven single bytes ----
        foreach (vec[i]) begin
            if (vec[i].wr) exp_acc(1'b1, vec[i].off, vec[i].dat);
            send(vec[i].ch);
            chk($sformatf("v%0d_ready_after_T", i), {31'b0, in_ready}, {31'b0, !vec[i].wr});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_ready_T1", i), {31'b0, in_ready}, 32'd1);
            chk($sformatf("v%0d_crx", i), 32'(crx), 32'(vec[i].ecrx));
            chk($sformatf("v%0d_cry", i), 32'(cry), 32'(vec[i].ecry));
        end
        chk("table_q_empty", 32'(exp_q.size()), 32'd0);

        // ---- 80 printables from reset wrap to the next row ----
        do_reset();
        for (int i = 0; i < COLS; i++) begin
            exp_acc(1'b1, i, 8'(8'h61 + (i % 26)));
            send(8'(8'h61 + (i % 26)));
        end
        @(negedge clk);
        wait_idle(10, "row_idle_timeout");
        chk("row_last_addr", mem_addr, BASE + 32'd79);
        chk("row_crx", 32'(crx), 32'd1);
        chk("row_cry", 32'(cry), 32'd1);
        chk("row_q_empty", 32'(exp_q.size()), 32'd0);

        // ---- form feed with a byte held valid through the clear ----
        for (int i = 0; i < CELLS; i++) exp_acc(1'b1, i, 8'h20);
        exp_acc(1'b1, 0, 8'h5A);
        @(negedge clk);
        in_valid = 1'b1;
        in_char  = 8'h0C;
        @(posedge clk);
        #1;
        in_char = 8'h5A;
        n = 0;
        while (!in_ready && n < 3400) begin
            @(negedge clk);
            n++;
        end
        chk("ff_idle_timeout", {31'b0, in_ready}, 32'd1);
        chk("ff_crx", 32'(crx), 32'd1);
        chk("ff_cry", 32'(cry), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_idle(10, "held_idle_timeout");
        @(negedge clk);
        chk("held_crx", 32'(crx), 32'd2);
        chk("held_cry", 32'(cry), 32'd0);
        chk("ff_q_empty", 32'(exp_q.size()), 32'd0);

        // ---- scroll on LF at the bottom row ----
        do_reset();
        for (int i = 0; i < ROWS - 1; i++) send(8'h0A);
        @(negedge clk);
        chk("scr_setup_cry", 32'(cry), 32'd39);
        do_preload = 1'b1;
        @(negedge clk);
        do_preload = 1'b0;
        for (int i = 0; i < (ROWS - 1) * COLS; i++) begin
            exp_acc(1'b0, i + COLS, 8'h00);
            exp_acc(1'b1, i, pat(i + COLS));
        end
        for (int i = (ROWS - 1) * COLS; i < CELLS; i++) exp_acc(1'b1, i, 8'h20);
        nstrobe = 0;
        send(8'h0A);
        bad = 0;
        n = 0;
        while (!in_ready && n < 7000) begin
            @(negedge clk);
            n++;
            if (in_ready == 1'b0 && (crx !== 7'd1 || cry !== 6'd39)) bad++;
        end
        chk("scr_idle_timeout", {31'b0, in_ready}, 32'd1);
        chk("scr_cursor_stable", 32'(bad), 32'd0);
        chk("scr_strobes", 32'(nstrobe), 32'd6320);
        chk("scr_crx", 32'(crx), 32'd1);
        chk("scr_cry", 32'(cry), 32'd39);
        bad = 0;
        for (int i = 0; i < CELLS; i++) begin
            if (i < (ROWS - 1) * COLS) begin
                if (ram[i] !== pat(i + COLS)) bad++;
            end else if (ram[i] !== 8'h20) begin
                bad++;
            end
        end
        chk("scr_ram_bad_cells", 32'(bad), 32'd0);
        chk("scr_q_empty", 32'(exp_q.size()), 32'd0);

        // ---- reset in the middle of a scroll ----
        for (int i = 0; i < (ROWS - 1) * COLS; i++) begin
            exp_acc(1'b0, i + COLS, 8'h00);
            exp_acc(1'b1, i, ram[i + COLS]);
        end
        send(8'h0A);
        repeat (100) @(negedge clk);
        chk("mid_busy", {31'b0, busy}, 32'd1);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        chk("mid_rst_strobe", {31'b0, mem_strobe}, 32'd0);
        chk("mid_rst_crx", 32'(crx), 32'd1);
        chk("mid_rst_cry", 32'(cry), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        nstrobe = 0;
        @(posedge clk);
        #1;
        chk("mid_rel_ready", {31'b0, in_ready}, 32'd1);
        repeat (5) @(negedge clk);
        chk("mid_no_strobes", 32'(nstrobe), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
